microstep_hbridge: RTL and testbench

- Clocked, parametrised successor to the dual H-bridge step/dir phase driver.
- Synchronises asynchronous step/dir inputs and keeps an electrical phase accumulator.
- Drives four bridge legs with full-step or half-step tables, or with sine/cosine PWM microstepping up to 1/2^MICRO_LOG2.
- Sits between the motion step generator and the external bridge pins; one instance per motor.

---
 rtl/microstep_hbridge.sv | 186 ++++++++++++++++++
 tb/tb_microstep_hbridge.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microstep_hbridge.sv
// Dual H-bridge driver: synchronised step/dir feed an electrical phase accumulator that drives
// the legs from full/half-step tables or from sine/cosine PWM with once-per-period duty latching.
module microstep_hbridge #(
    parameter int unsigned MICRO_LOG2 = 6,
    parameter int unsigned PWM_BITS   = 8
) (
    input  logic                  CLK,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  step,
    input  logic                  dir,
    input  logic [2:0]            microsteps,
    output logic                  phase_a1,
    output logic                  phase_a2,
    output logic                  phase_b1,
    output logic                  phase_b2,
    output logic [MICRO_LOG2+1:0] phase
);
    localparam int unsigned PhaseBits    = MICRO_LOG2 + 2;
    localparam int unsigned QuarterSteps = 1 << MICRO_LOG2;

    // Quarter-wave table, evaluated at elaboration.
    function automatic logic [PWM_BITS-1:0] sine_entry(input int unsigned k);
        real full_scale;
        real angle;
        full_scale = real'((1 << PWM_BITS) - 1);
        angle      = 3.14159265358979323846 / 2.0 * real'(k) / real'(QuarterSteps);
        return PWM_BITS'($rtoi(full_scale * $sin(angle) + 0.5));
    endfunction

    // Odd quadrants run the quarter-wave backwards.
    function automatic logic [MICRO_LOG2:0] lut_index(input logic [PhaseBits-1:0] p);
        logic [MICRO_LOG2:0] i;
        i = {1'b0, p[MICRO_LOG2-1:0]};
        return p[MICRO_LOG2] ? (MICRO_LOG2 + 1)'(QuarterSteps) - i : i;
    endfunction

    function automatic logic [3:0] full_step_legs(input logic [1:0] sel);
        logic [3:0] legs;
        unique case (sel)
            2'd0: legs = 4'b1010;
            2'd1: legs = 4'b0110;
            2'd2: legs = 4'b0101;
            2'd3: legs = 4'b1001;
        endcase
        return legs;
    endfunction

    function automatic logic [3:0] half_step_legs(input logic [2:0] sel);
        logic [3:0] legs;
        unique case (sel)
            3'd0: legs = 4'b1010;
            3'd1: legs = 4'b0010;
            3'd2: legs = 4'b0110;
            3'd3: legs = 4'b0100;
            3'd4: legs = 4'b0101;
            3'd5: legs = 4'b0001;
            3'd6: legs = 4'b1001;
            3'd7: legs = 4'b1000;
        endcase
        return legs;
    endfunction

    logic [PWM_BITS-1:0] lut [QuarterSteps+1];
    for (genvar k = 0; k <= QuarterSteps; k++) begin : g_lut
        assign lut[k] = sine_entry(k);
    end

    logic step_s1_q, step_s2_q, step_prev_q;
    logic dir_s1_q, dir_s2_q;
    logic step_edge;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            step_s1_q   <= 1'b0;
            step_s2_q   <= 1'b0;
            step_prev_q <= 1'b0;
            dir_s1_q    <= 1'b0;
            dir_s2_q    <= 1'b0;
        end else begin
            step_s1_q   <= step;
            step_s2_q   <= step_s1_q;
            step_prev_q <= step_s2_q;
            dir_s1_q    <= dir;
            dir_s2_q    <= dir_s1_q;
        end
    end

    assign step_edge = step_s2_q & ~step_prev_q;

    logic [PhaseBits-1:0] step_inc;
    int                   inc_shift;
    logic [PhaseBits-1:0] phase_q, phase_d;

    always_comb begin
        inc_shift = 0;
        if (microsteps <= 3'd1) begin
            inc_shift = int'(MICRO_LOG2);
        end else if (microsteps == 3'd2) begin
            inc_shift = int'(MICRO_LOG2) - 1;
        end else begin
            inc_shift = int'(PhaseBits) - int'(microsteps);
        end
        // Divisions finer than the accumulator resolution saturate at one LSB.
        if (inc_shift < 0) begin
            inc_shift = 0;
        end
        step_inc = PhaseBits'(1) << inc_shift;
    end

    always_comb begin
        phase_d = phase_q;
        if (step_edge) begin
            phase_d = dir_s2_q ? phase_q - step_inc : phase_q + step_inc;
        end
    end

    logic [PWM_BITS-1:0]  pwm_cnt_q;
    logic [PWM_BITS-1:0]  duty_a_q, duty_b_q;
    logic                 neg_a_q, neg_b_q;
    logic                 run_q;
    logic [PhaseBits-1:0] phase_b_ref;
    logic [PWM_BITS-1:0]  mag_a, mag_b;
    logic                 pwm_wrap;

    assign phase_b_ref = phase_q + PhaseBits'(QuarterSteps);
    assign mag_a       = lut[lut_index(phase_q)];
    assign mag_b       = lut[lut_index(phase_b_ref)];
    assign pwm_wrap    = &pwm_cnt_q;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            phase_q   <= '0;
            pwm_cnt_q <= '0;
            duty_a_q  <= '0;
            duty_b_q  <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            // Duty and polarity only move at the period boundary so no period is truncated.
            if (pwm_wrap) begin
                duty_a_q <= mag_a;
                duty_b_q <= mag_b;
                neg_a_q  <= phase_q[PhaseBits-1];
                neg_b_q  <= phase_b_ref[PhaseBits-1];
                run_q    <= enable;
            end else if (!enable) begin
                run_q <= 1'b0;
            end
        end
    end

    logic [3:0] legs_q, legs_d;
    logic       pwm_on_a, pwm_on_b;

    always_comb begin
        legs_d   = 4'b0000;
        pwm_on_a = pwm_cnt_q < duty_a_q;
        pwm_on_b = pwm_cnt_q < duty_b_q;
        if (enable) begin
            if (microsteps <= 3'd1) begin
                legs_d = full_step_legs(phase_q[PhaseBits-1 -: 2]);
            end else if (microsteps == 3'd2) begin
                legs_d = half_step_legs(phase_q[PhaseBits-1 -: 3]);
            end else if (run_q) begin
                legs_d = {pwm_on_a & ~neg_a_q, pwm_on_a & neg_a_q,
                          pwm_on_b & ~neg_b_q, pwm_on_b & neg_b_q};
            end
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            legs_q <= 4'b0000;
        end else begin
            legs_q <= legs_d;
        end
    end

    assign {phase_a1, phase_a2, phase_b1, phase_b2} = legs_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_microstep_hbridge.sv
// Randomised bench for microstep_hbridge: a cycle-level behavioural model of the phase,
// table and PWM rules is compared against the DUT every cycle, plus literal spot checks.
module tb_microstep_hbridge;
    localparam int MicroLog2 = 6;
    localparam int Quarter   = 64;
    localparam int Cycle     = 256;
    localparam int Period    = 256;

    logic       CLK = 1'b0;
    logic       resetn, enable, step, dir;
    logic [2:0] microsteps;
    logic       a1, a2, b1, b2;
    logic [7:0] phase;

    microstep_hbridge #(.MICRO_LOG2(6), .PWM_BITS(8)) dut (
        .CLK       (CLK),
        .resetn    (resetn),
        .enable    (enable),
        .step      (step),
        .dir       (dir),
        .microsteps(microsteps),
        .phase_a1  (a1),
        .phase_a2  (a2),
        .phase_b1  (b1),
        .phase_b2  (b2),
        .phase     (phase)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lut_m [Quarter+1];

    int m_phase, m_cnt, m_duty_a, m_duty_b;
    bit m_neg_a, m_neg_b, m_run;
    int pend_due [$];
    bit pend_dir [$];

    logic [3:0] exp_legs;
    logic [7:0] exp_phase;
    bit         chk_en = 1'b0;

    logic [3:0] full_tab [4] = '{4'b1010, 4'b0110, 4'b0101, 4'b1001};
    logic [3:0] half_tab [8] = '{4'b1010, 4'b0010, 4'b0110, 4'b0100,
                                 4'b0101, 4'b0001, 4'b1001, 4'b1000};

    function automatic int step_size(input int mode);
        int sh;
        if (mode <= 1) sh = MicroLog2;
        else if (mode == 2) sh = MicroLog2 - 1;
        else sh = MicroLog2 + 2 - mode;
        if (sh < 0) sh = 0;
        return 1 << sh;
    endfunction

    // Signed sine sample at electrical phase p.
    function automatic int wave(input int p);
        int q, i;
        p = p % Cycle;
        q = p / Quarter;
        i = p % Quarter;
        case (q)
            0: return lut_m[i];
            1: return lut_m[Quarter - i];
            2: return -lut_m[i];
            default: return -lut_m[Quarter - i];
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_duty_a = 0; m_duty_b = 0;
        m_neg_a = 0; m_neg_b = 0; m_run = 0;
        pend_due.delete();
        pend_dir.delete();
        exp_legs = 4'b0000;
        exp_phase = 8'd0;
    endtask

    // State after the clock edge that has just occurred, from the state and inputs before it.
    task automatic model_edge();
        int mode, va, vb;
        logic [3:0] legs;
        mode = int'(microsteps);
        cyc++;
        legs = 4'b0000;
        if (enable) begin
            if (mode <= 1) legs = full_tab[m_phase / Quarter];
            else if (mode == 2) legs = half_tab[m_phase / (Quarter / 2)];
            else if (m_run) begin
                if (m_cnt < m_duty_a) legs[3:2] = m_neg_a ? 2'b01 : 2'b10;
                if (m_cnt < m_duty_b) legs[1:0] = m_neg_b ? 2'b01 : 2'b10;
            end
        end
        if (m_cnt == Period - 1) begin
            va = wave(m_phase);
            vb = wave(m_phase + Quarter);
            m_neg_a = (va < 0); m_duty_a = (va < 0) ? -va : va;
            m_neg_b = (vb < 0); m_duty_b = (vb < 0) ? -vb : vb;
            m_run = enable;
        end else if (!enable) begin
            m_run = 0;
        end
        m_cnt = (m_cnt + 1) % Period;
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            if (pend_dir[0]) m_phase = (m_phase - step_size(mode) + Cycle) % Cycle;
            else m_phase = (m_phase + step_size(mode)) % Cycle;
            void'(pend_due.pop_front());
            void'(pend_dir.pop_front());
        end
        exp_legs = legs;
        exp_phase = 8'(m_phase);
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic drive_step(input bit v);
        if (v && !step) begin
            pend_due.push_back(cyc + 3);
            pend_dir.push_back(dir);
        end
        step = v;
    endtask

    task automatic pulse(input bit d, input int hi, input int lo);
        dir = d;
        drive_step(1'b1);
        repeat (hi) tick();
        drive_step(1'b0);
        repeat (lo) tick();
    endtask

    task automatic count_window(input int n, output int ca1, output int ca2,
                                output int cb1, output int cb2);
        ca1 = 0; ca2 = 0; cb1 = 0; cb2 = 0;
        repeat (n) begin
            tick();
            ca1 += int'(a1); ca2 += int'(a2); cb1 += int'(b1); cb2 += int'(b2);
        end
    endtask

    task automatic wait_model_cnt(input int target);
        for (int i = 0; i < Period && m_cnt != target; i++) tick();
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                total++;
                if ({a1, a2, b1, b2} !== exp_legs || phase !== exp_phase) begin
                    bad++;
                    $display("FAIL cycle %0d: legs=%b phase=%0d, expected legs=%b phase=%0d",
                             cyc, {a1, a2, b1, b2}, phase, exp_legs, exp_phase);
                end
                total++;
                if ((a1 && a2) || (b1 && b2)) begin
                    bad++;
                    $display("FAIL shoot-through cycle %0d: legs=%b, expected no leg pair high",
                             cyc, {a1, a2, b1, b2});
                end
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int ca1, ca2, cb1, cb2, overlap;
        int lit_phase [4] = '{64, 128, 192, 0};
        logic [3:0] lit_legs [4] = '{4'b0110, 4'b0101, 4'b1001, 4'b1010};

        for (int k = 0; k <= Quarter; k++)
            lut_m[k] = $rtoi(255.0 * $sin(3.14159265358979 * real'(k) / 128.0) + 0.5);
        check("lut L(0)", lut_m[0], 0);
        check("lut L(32)", lut_m[32], 180);
        check("lut L(64)", lut_m[64], 255);
        check("lut L(30)", lut_m[30], 171);

        resetn = 1'b0; enable = 1'b0; step = 1'b0; dir = 1'b0; microsteps = 3'd0;
        fork
            compare_loop();
        join_none
        repeat (3) @(posedge CLK);
        #1;
        check("reset legs", int'({a1, a2, b1, b2}), 0);
        check("reset phase", int'(phase), 0);
        resetn = 1'b1;
        model_reset();
        chk_en = 1'b1;
        enable = 1'b1;
        microsteps = 3'd0;
        repeat (4) tick();

        // Full step forward.
        for (int s = 0; s < 4; s++) begin
            pulse(1'b0, 1, 3);
            check("full-step phase", int'(phase), lit_phase[s]);
            check("full-step legs", int'({a1, a2, b1, b2}), int'(lit_legs[s]));
        end

        // Half step backward with wrap.
        microsteps = 3'd2;
        pulse(1'b1, 1, 3);
        check("half-step phase", int'(phase), 224);
        check("half-step legs", int'({a1, a2, b1, b2}), 4'b1000);
        repeat (8) pulse(1'b1, 2, 2);
        tick();
        check("half-step wrap phase", int'(phase), 224);

        // Microstep at 45 degrees.
        repeat (2) pulse(1'b0, 1, 3);
        check("phase 32", int'(phase), 32);
        microsteps = 3'd7;
        repeat (300) tick();
        count_window(Period, ca1, ca2, cb1, cb2);
        check("ph32 a1 duty", ca1, 180);
        check("ph32 a2 duty", ca2, 0);
        check("ph32 b1 duty", cb1, 180);
        check("ph32 b2 duty", cb2, 0);

        // Microstep at 225 degrees: both phases negative.
        microsteps = 3'd2;
        repeat (4) pulse(1'b0, 1, 3);
        check("phase 160", int'(phase), 160);
        microsteps = 3'd7;
        repeat (300) tick();
        count_window(Period, ca1, ca2, cb1, cb2);
        check("ph160 a1 duty", ca1, 0);
        check("ph160 a2 duty", ca2, 180);
        check("ph160 b1 duty", cb1, 0);
        check("ph160 b2 duty", cb2, 180);
        overlap = 0;
        repeat (10 * Period) begin
            tick();
            if ((a1 && a2) || (b1 && b2)) overlap++;
        end
        check("ph160 overlap cycles", overlap, 0);

        // Disable while stepping.
        enable = 1'b0;
        microsteps = 3'd0;
        tick();
        check("disabled legs", int'({a1, a2, b1, b2}), 0);
        pulse(1'b0, 1, 3);
        check("disabled phase advance", int'(phase), 224);
        check("disabled legs still low", int'({a1, a2, b1, b2}), 0);
        enable = 1'b1;
        tick();
        check("re-enabled legs", int'({a1, a2, b1, b2}), 4'b1001);

        // Step mid PWM period: new duty only after the wrap.
        microsteps = 3'd7;
        repeat (300) tick();
        wait_model_cnt(100);
        pulse(1'b0, 1, 3);
        check("mid-period step phase", int'(phase), 226);
        wait_model_cnt(5);
        count_window(Period, ca1, ca2, cb1, cb2);
        check("ph226 a1 duty", ca1, 0);
        check("ph226 a2 duty", ca2, 171);

        // Random modes, directions, enables and pacing.
        for (int it = 0; it < 60; it++) begin
            microsteps = 3'($urandom_range(0, 7));
            enable = ($urandom_range(0, 4) != 0);
            repeat ($urandom_range(1, 4))
                pulse(1'($urandom_range(0, 1)), $urandom_range(1, 3), $urandom_range(2, 6));
            repeat ($urandom_range(0, 200)) tick();
        end

        // Asynchronous reset mid-operation.
        enable = 1'b1;
        microsteps = 3'd2;
        pulse(1'b0, 1, 3);
        chk_en = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("async reset legs", int'({a1, a2, b1, b2}), 0);
        check("async reset phase", int'(phase), 0);
        step = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        resetn = 1'b1;
        model_reset();
        chk_en = 1'b1;
        repeat (2) tick();
        for (int it = 0; it < 10; it++) begin
            microsteps = 3'($urandom_range(0, 7));
            pulse(1'($urandom_range(0, 1)), $urandom_range(1, 3), $urandom_range(2, 6));
        end
        repeat (300) tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
